// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcode/funct fields,
// FSM state type, internal ALU-op classes and ALU control codes.
package mips_decls_p;

  typedef logic [5:0] opcode_t;
  typedef logic [5:0] funct_t;

  localparam opcode_t RTYPE = 6'b000000;
  localparam opcode_t J     = 6'b000010;
  localparam opcode_t BEQ   = 6'b000100;
  localparam opcode_t ADDI  = 6'b001000;
  localparam opcode_t LW    = 6'b100011;
  localparam opcode_t SW    = 6'b101011;

  localparam funct_t ADD = 6'b100000;
  localparam funct_t SUB = 6'b100010;
  localparam funct_t AND = 6'b100100;
  localparam funct_t OR  = 6'b100101;
  localparam funct_t SLT = 6'b101010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } statetype_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// enables / mux selects / debug state out.
interface mc_controller_if;
  import mips_decls_p::*;

  opcode_t    opcode;
  funct_t     funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  statetype_t state;

  // Controller side
  modport master (
    input  opcode, funct, zero,
    output pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
           regdst, alusrcb, pcsrc, alucontrol, state
  );

  // Datapath side
  modport slave (
    output opcode, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
           regdst, alusrcb, pcsrc, alucontrol, state
  );
endinterface

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps the controller's ALU-op class and the funct field to
// the 3-bit ALU control code. Purely combinational.
module aludec
  import mips_decls_p::*;
(
  input  aluop_t     aluop,
  input  funct_t     funct,
  output logic [2:0] alucontrol
);

  // Select the ALU operation; unknown funct and the unused op class fall back to add
  always_comb begin
    // NOTE: assign a default before any branching so no path leaves the output unassigned (which would infer a latch).
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          ADD:     alucontrol = ALU_ADD;
          SUB:     alucontrol = ALU_SUB;
          AND:     alucontrol = ALU_AND;
          OR:      alucontrol = ALU_OR;
          SLT:     alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing datapath enables and
// mux selects; pcen is the only output combining the zero flag directly.
module mc_controller
  import mips_decls_p::*;
(
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.master bus
);

  statetype_t state_q, state_d, out_state;
  aluop_t     aluop;
  logic       pcwrite, branch;
  logic       irwrite_raw, regwrite_raw, memwrite_raw;

  // State register; reset abandons any instruction in flight and returns to FETCH
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // While reset is held, outputs show FETCH values regardless of the stored state
  assign out_state = reset ? FETCH : state_q;

  // Next-state and per-state output decode
  always_comb begin
    state_d       = FETCH;
    aluop         = ALUOP_ADD;
    pcwrite       = 1'b0;
    branch        = 1'b0;
    irwrite_raw   = 1'b0;
    regwrite_raw  = 1'b0;
    memwrite_raw  = 1'b0;
    bus.alusrca   = 1'b0;
    bus.iord      = 1'b0;
    bus.memtoreg  = 1'b0;
    bus.regdst    = 1'b0;
    bus.alusrcb   = 2'b00;
    bus.pcsrc     = 2'b00;

    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (bus.opcode)
          LW, SW:  state_d = MEMADR;
          RTYPE:   state_d = RTYPEEX;
          BEQ:     state_d = BEQEX;
          ADDI:    state_d = ADDIEX;
          J:       state_d = JEX;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (bus.opcode == SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase

    case (out_state)
      FETCH: begin
        bus.alusrcb = 2'b01;
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
      end
      DECODE:  bus.alusrcb = 2'b11;
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      MEMRD:   bus.iord = 1'b1;
      MEMWB: begin
        bus.memtoreg = 1'b1;
        regwrite_raw = 1'b1;
      end
      MEMWR: begin
        bus.iord     = 1'b1;
        memwrite_raw = 1'b1;
      end
      RTYPEEX: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        bus.regdst   = 1'b1;
        regwrite_raw = 1'b1;
      end
      BEQEX: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_SUB;
        bus.pcsrc   = 2'b01;
        branch      = 1'b1;
      end
      ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      ADDIWB:  regwrite_raw = 1'b1;
      JEX: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural write enables are suppressed for the whole reset window
  assign bus.pcen     = (pcwrite | (branch & bus.zero)) & ~reset;
  assign bus.irwrite  = irwrite_raw & ~reset;
  assign bus.regwrite = regwrite_raw & ~reset;
  assign bus.memwrite = memwrite_raw & ~reset;
  assign bus.state    = state_q;

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus random
// instruction streams compared cycle by cycle against an instruction-level
// reference model (state sequence per opcode, control values per step).
module tb_mc_controller;
  import mips_decls_p::*;

  typedef struct packed {
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
  } ctrl_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected state at step k (1-based) of an instruction, plus its length
  function automatic statetype_t exp_state(input logic [5:0] op, input int k, output int len);
    statetype_t seq[$];
    seq = '{FETCH, DECODE};
    case (op)
      6'b100011: seq = {seq, MEMADR, MEMRD, MEMWB};
      6'b101011: seq = {seq, MEMADR, MEMWR};
      6'b000000: seq = {seq, RTYPEEX, RTYPEWB};
      6'b000100: seq = {seq, BEQEX};
      6'b001000: seq = {seq, ADDIEX, ADDIWB};
      6'b000010: seq = {seq, JEX};
      default: ;
    endcase
    len = seq.size();
    return seq[k-1];
  endfunction

  // Expected controls at step k of an instruction
  function automatic ctrl_t exp_ctrl(input logic [5:0] op, input logic [5:0] fn,
                                     input int k, input logic z);
    ctrl_t c;
    c = '0;
    c.alucontrol = 3'b010;
    if (k == 1) begin
      c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcen = 1'b1;
    end else if (k == 2) begin
      c.alusrcb = 2'b11;
    end else begin
      case (op)
        6'b100011: begin
          if (k == 3) begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
          if (k == 4) c.iord = 1'b1;
          if (k == 5) begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
        end
        6'b101011: begin
          if (k == 3) begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
          if (k == 4) begin c.iord = 1'b1; c.memwrite = 1'b1; end
        end
        6'b000000: begin
          if (k == 3) begin c.alusrca = 1'b1; c.alucontrol = funct_alu(fn); end
          if (k == 4) begin c.regdst = 1'b1; c.regwrite = 1'b1; end
        end
        6'b000100: begin
          c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = z;
        end
        6'b001000: begin
          if (k == 3) begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
          if (k == 4) c.regwrite = 1'b1;
        end
        6'b000010: begin c.pcsrc = 2'b10; c.pcen = 1'b1; end
        default: ;
      endcase
    end
    return c;
  endfunction

  function automatic ctrl_t reset_ctrl();
    ctrl_t c;
    c = '0;
    c.alucontrol = 3'b010;
    c.alusrcb = 2'b01;
    return c;
  endfunction

  function automatic ctrl_t got_ctrl();
    return '{bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.alusrca, bus.iord,
             bus.memtoreg, bus.regdst, bus.alusrcb, bus.pcsrc, bus.alucontrol};
  endfunction

  // One cycle: drive inputs at the falling edge, sample shortly after
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic rst, input statetype_t est, input ctrl_t ec, input string tag);
    @(negedge clk);
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    reset      = rst;
    #1;
    check({tag, ".state"}, 32'(bus.state), 32'(est));
    check({tag, ".ctrl"}, 32'(got_ctrl()), 32'(ec));
  endtask

  // zsel: 0/1 fixed zero flag, anything else random per cycle
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zsel,
                           input string tag);
    int len;
    statetype_t st;
    logic z;
    st = exp_state(op, 1, len);
    for (int k = 1; k <= len; k++) begin
      z  = (zsel == 0 || zsel == 1) ? 1'(zsel) : 1'($urandom_range(0, 1));
      st = exp_state(op, k, len);
      step(op, fn, z, 1'b0, st, exp_ctrl(op, fn, k, z), $sformatf("%s.c%0d", tag, k));
    end
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] legal [6];
    logic [5:0] v;
    legal = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    if ($urandom_range(0, 7) != 0) return legal[$urandom_range(0, 5)];
    do v = 6'($urandom); while (v inside {legal});
    return v;
  endfunction

  function automatic logic [5:0] rand_fn();
    logic [5:0] legal [5];
    legal = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    if ($urandom_range(0, 5) == 0) return 6'($urandom);
    return legal[$urandom_range(0, 4)];
  endfunction

  initial begin
    int dummy;
    bus.opcode = 6'b0;
    bus.funct  = 6'b0;
    bus.zero   = 1'b0;
    reset      = 1'b1;

    // Reset held for two cycles: FETCH state, writes suppressed
    for (int i = 0; i < 2; i++)
      step(6'b0, 6'b0, 1'b1, 1'b1, FETCH, reset_ctrl(), $sformatf("reset%0d", i));

    // Directed scenarios
    run_instr(6'b100011, 6'b000000, 2, "lw");
    run_instr(6'b101011, 6'b000000, 2, "sw");
    run_instr(6'b000000, 6'b100010, 2, "r_sub");
    run_instr(6'b000000, 6'b101010, 2, "r_slt");
    run_instr(6'b000000, 6'b111111, 2, "r_unk");
    run_instr(6'b000100, 6'b000000, 1, "beq_taken");
    run_instr(6'b000100, 6'b000000, 0, "beq_not");
    run_instr(6'b000010, 6'b000000, 2, "j");
    run_instr(6'b111111, 6'b000000, 2, "illegal");
    run_instr(6'b001000, 6'b000000, 2, "addi");

    // Reset during MEMRD of a load: return to FETCH with no writeback
    for (int k = 1; k <= 3; k++)
      step(6'b100011, 6'b0, 1'b0, 1'b0, exp_state(6'b100011, k, dummy),
           exp_ctrl(6'b100011, 6'b0, k, 1'b0), $sformatf("lwrst.c%0d", k));
    step(6'b100011, 6'b0, 1'b0, 1'b1, MEMRD, reset_ctrl(), "lwrst.memrd");
    step(6'b100011, 6'b0, 1'b0, 1'b1, FETCH, reset_ctrl(), "lwrst.after");
    run_instr(6'b101011, 6'b000000, 2, "post_rst_sw");

    // Random instruction stream
    for (int i = 0; i < 200; i++)
      run_instr(rand_op(), rand_fn(), 2, $sformatf("rnd%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
